// File: rtl/press_pulse_pkg.sv
// Shared types and defaults for the push-button press pulse generator.
package press_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_REPEAT_CYCLES   = 25000000;

    // Counter width large enough to hold max(a, b) - 1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m >= 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/press_pulse_gen_sync_chain.sv
// STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/press_pulse_gen.sv
// Synchronise and debounce a player button; one registered trigger pulse per press.
// Optional auto-repeat while held: define PRESS_PULSE_AUTO_REPEAT_EN.
module press_pulse_gen
    import press_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic en,
    output logic trigger,
    output logic pressed
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trigger_q, trigger_d;
    logic          pressed_q, pressed_d;

`ifdef PRESS_PULSE_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rcnt_q, rcnt_d;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        trigger_d = 1'b0;
`ifdef PRESS_PULSE_AUTO_REPEAT_EN
        // Anything other than an uninterrupted HELD cycle restarts the repeat period.
        rcnt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    trigger_d = en;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef PRESS_PULSE_AUTO_REPEAT_EN
                else if (rcnt_q == REP_LAST) begin
                    trigger_d = en;
                    rcnt_d    = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered level follows the state being entered, so it lines up with trigger.
        pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            trigger_q <= 1'b0;
            pressed_q <= 1'b0;
`ifdef PRESS_PULSE_AUTO_REPEAT_EN
            rcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trigger_q <= trigger_d;
            pressed_q <= pressed_d;
`ifdef PRESS_PULSE_AUTO_REPEAT_EN
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    assign trigger = trigger_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_press_pulse_gen.sv
// Directed bench for press_pulse_gen with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_CYCLES=8.
module tb_press_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic en;
    logic trigger;
    logic pressed;

    int n_tests = 0;
    int n_fail  = 0;

    press_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .en      (en),
        .trigger (trigger),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    // Advance one active edge, then settle so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_released();
        btn_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = 1'b1; en = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (trigger !== 1'b0) begin
            n_fail++; $display("FAIL reset_trigger: got %b want 0", trigger);
        end
        n_tests++;
        if (pressed !== 1'b0) begin
            n_fail++; $display("FAIL reset_pressed: got %b want 0", pressed);
        end
        btn_raw = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    // Press sampled at edge N (i=0): trigger only after N+6, pressed from N+6.
    task automatic test_clean_press();
        en = 1'b1;
        btn_raw = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            tick();
            n_tests++;
            if (trigger !== (i == 6)) begin
                n_fail++; $display("FAIL clean_trigger[N+%0d]: got %b want %b", i, trigger, (i == 6));
            end
            n_tests++;
            if (pressed !== (i >= 6)) begin
                n_fail++; $display("FAIL clean_pressed[N+%0d]: got %b want %b", i, pressed, (i >= 6));
            end
        end
        settle_released();
    endtask

    task automatic test_bounce();
        int trig_cnt = 0;
        int press_cnt = 0;
        en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                btn_raw = (c < 3);
                tick();
                if (trigger === 1'b1) trig_cnt++;
                if (pressed !== 1'b0) press_cnt++;
            end
        end
        repeat (4) tick();
        n_tests++;
        if (trig_cnt !== 0) begin
            n_fail++; $display("FAIL bounce_trigger: got %0d pulses want 0", trig_cnt);
        end
        n_tests++;
        if (press_cnt !== 0) begin
            n_fail++; $display("FAIL bounce_pressed: got %0d high cycles want 0", press_cnt);
        end
    endtask

    task automatic test_release_bounce();
        logic [7:0] pat;
        int trig_cnt = 0;
        int drop_cnt = 0;
        pat = 8'b1100_1100;  // bit i driven at step i: 0,0,1,1,0,0,1,1
        en = 1'b1;
        btn_raw = 1'b1;
        repeat (10) tick();
        n_tests++;
        if (pressed !== 1'b1) begin
            n_fail++; $display("FAIL relb_held: got %b want 1", pressed);
        end
        for (int i = 0; i < 8; i++) begin
            btn_raw = pat[i];
            tick();
            if (trigger === 1'b1) trig_cnt++;
            if (pressed !== 1'b1) drop_cnt++;
        end
        n_tests++;
        if (drop_cnt !== 0) begin
            n_fail++; $display("FAIL relb_pressed_glitch: got %0d low cycles want 0", drop_cnt);
        end
        btn_raw = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            tick();
            if (trigger === 1'b1) trig_cnt++;
            n_tests++;
            if (pressed !== (i < 6)) begin
                n_fail++; $display("FAIL relb_pressed[M+%0d]: got %b want %b", i, pressed, (i < 6));
            end
        end
        n_tests++;
        if (trig_cnt !== 0) begin
            n_fail++; $display("FAIL relb_trigger: got %0d pulses want 0", trig_cnt);
        end
        settle_released();
    endtask

    task automatic test_enable_gating();
        int trig_cnt = 0;
        en = 1'b0;
        btn_raw = 1'b1;
        repeat (10) begin
            tick();
            if (trigger === 1'b1) trig_cnt++;
        end
        n_tests++;
        if (pressed !== 1'b1) begin
            n_fail++; $display("FAIL engate_pressed: got %b want 1", pressed);
        end
        en = 1'b1;
        repeat (20) begin
            tick();
            if (trigger === 1'b1) trig_cnt++;
        end
        n_tests++;
        if (trig_cnt !== 0) begin
            n_fail++; $display("FAIL engate_suppressed: got %0d pulses want 0", trig_cnt);
        end
        settle_released();
        n_tests++;
        if (pressed !== 1'b0) begin
            n_fail++; $display("FAIL engate_released: got %b want 0", pressed);
        end
        trig_cnt = 0;
        btn_raw = 1'b1;
        repeat (14) begin
            tick();
            if (trigger === 1'b1) trig_cnt++;
        end
        n_tests++;
        if (trig_cnt !== 1) begin
            n_fail++; $display("FAIL engate_second_press: got %0d pulses want 1", trig_cnt);
        end
        settle_released();
    endtask

    // Reset at edge R while in PRESS_WAIT; button held, so a fresh press is sampled at R+1.
    task automatic test_reset_mid_press();
        en = 1'b1;
        btn_raw = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (trigger !== 1'b0 || pressed !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got trig=%b pressed=%b want 0 0", trigger, pressed);
        end
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_tests++;
            if (trigger !== (i == 7)) begin
                n_fail++; $display("FAIL rstmid_trigger[R+%0d]: got %b want %b", i, trigger, (i == 7));
            end
        end
        n_tests++;
        if (pressed !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pressed: got %b want 1", pressed);
        end
        settle_released();
    endtask

    // Acceptance at N+6; with auto-repeat further pulses at N+14, N+22, N+30.
    task automatic test_auto_repeat();
        int trig_cnt = 0;
        int back2back = 0;
        int exp_cnt;
        logic prev = 1'b0;
`ifdef PRESS_PULSE_AUTO_REPEAT_EN
        exp_cnt = 4;
`else
        exp_cnt = 1;
`endif
        en = 1'b1;
        btn_raw = 1'b1;
        for (int i = 0; i <= 36; i++) begin
            tick();
            if (trigger === 1'b1) trig_cnt++;
            if (prev === 1'b1 && trigger === 1'b1) back2back++;
            prev = trigger;
        end
        n_tests++;
        if (trig_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL repeat_count: got %0d pulses want %0d", trig_cnt, exp_cnt);
        end
        n_tests++;
        if (back2back !== 0) begin
            n_fail++; $display("FAIL repeat_consecutive: got %0d back-to-back want 0", back2back);
        end
        settle_released();
    endtask

    initial begin
        rst = 1'b1; btn_raw = 1'b0; en = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_enable_gating();
        test_reset_mid_press();
        test_auto_repeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
